// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;
    logic              ack_a;
    logic              ack_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic              busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;
    logic              mem_wr;
    logic              mem_rd;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_dout,
        output ack_a, ack_b, rdata_a, rdata_b, busy, mem_addr, mem_din, mem_wr, mem_rd
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, mem_dout,
        input  ack_a, ack_b, rdata_a, rdata_b, busy, mem_addr, mem_din, mem_wr, mem_rd
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous memory.
// One transaction in flight: IDLE -> ACCESS -> LATCH -> DONE, ack held until req drops.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StAccess, StLatch, StDone} state_e;

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;  // 0: prefer A on a tie
    logic              win_q, win_d;  // 0: A owns the current transaction
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_a || bus.req_b) begin
                    win_d   = (bus.req_a && bus.req_b) ? ptr_q : bus.req_b;
                    ptr_d   = ~win_d;
                    we_d    = win_d ? bus.we_b    : bus.we_a;
                    addr_d  = win_d ? bus.addr_b  : bus.addr_a;
                    wdata_d = win_d ? bus.wdata_b : bus.wdata_a;
                    state_d = StAccess;
                end
            end
            StAccess: state_d = StLatch;
            StLatch: begin
                // Memory registered its output on the ACCESS exit edge.
                if (!we_q) begin
                    if (win_q) rdata_b_d = bus.mem_dout;
                    else       rdata_a_d = bus.mem_dout;
                end
                state_d = StDone;
            end
            StDone: begin
                if (!(win_q ? bus.req_b : bus.req_a)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            ptr_q     <= 1'b0;
            win_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = wdata_q;
    assign bus.mem_wr   = (state_q == StAccess) &&  we_q;
    assign bus.mem_rd   = (state_q == StAccess) && !we_q;
    assign bus.busy     = (state_q != StIdle);
    assign bus.ack_a    = (state_q == StDone) && !win_q;
    assign bus.ack_b    = (state_q == StDone) &&  win_q;
    assign bus.rdata_a  = rdata_a_q;
    assign bus.rdata_b  = rdata_b_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized two-requester
// traffic scored against a transaction-level memory model.
module tb_mem_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    mem_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] mem    [16];
    logic [7:0] refmem [16];
    logic       mem_init = 1'b1;
    logic [7:0] exp_rd_a, exp_rd_b;
    int         order[$];
    int         overlap   = 0;
    int         wr_pulses = 0;
    int         rd_pulses = 0;

    // Synchronous memory: write and read-register on the strobe edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i * 37 + 5);
        end else begin
            if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_din;
            if (bus.mem_rd) bus.mem_dout <= mem[bus.mem_addr];
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.mem_wr && bus.mem_rd) overlap++;
            if (bus.mem_wr) wr_pulses++;
            if (bus.mem_rd) rd_pulses++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_a = 0; bus.req_b = 0; bus.we_a = 0; bus.we_b = 0;
        bus.addr_a = '0; bus.addr_b = '0; bus.wdata_a = '0; bus.wdata_b = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin tick(); n++; end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_idle: busy=%0b required 0", bus.busy);
        end
    endtask

    task automatic pulse_reset();
        reset = 1;
        tick();
        reset = 0;
        exp_rd_a = 8'h00;
        exp_rd_b = 8'h00;
    endtask

    task automatic test_reset();
        reset = 1; mem_init = 1;
        idle_inputs();
        repeat (3) tick();
        n_cmp++;
        if ({bus.ack_a, bus.ack_b, bus.busy, bus.mem_wr, bus.mem_rd} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ack_a/ack_b/busy/wr/rd=%b required 00000",
                     {bus.ack_a, bus.ack_b, bus.busy, bus.mem_wr, bus.mem_rd});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_din} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_membus: addr/din=%h required 000", {bus.mem_addr, bus.mem_din});
        end
        n_cmp++;
        if ({bus.rdata_a, bus.rdata_b} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_rdata: rdata=%h required 0000", {bus.rdata_a, bus.rdata_b});
        end
        for (int i = 0; i < 16; i++) refmem[i] = 8'(i * 37 + 5);
        mem_init = 0; reset = 0;
        exp_rd_a = 8'h00; exp_rd_b = 8'h00;
        tick();
    endtask

    task automatic test_write_read();
        int wr0, lat;
        wr0 = wr_pulses;
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4'd3; bus.wdata_a = 8'h5A;
        tick();
        n_cmp++;
        if ({bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din} !== {1'b1, 1'b0, 4'd3, 8'h5A}) begin
            n_fail++;
            $display("FAIL wr_strobe: wr/rd/addr/din=%b/%b/%h/%h required 1/0/3/5a",
                     bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din);
        end
        bus.addr_a = 4'd9; bus.wdata_a = 8'hFF;  // must not affect the granted transaction
        tick();
        n_cmp++;
        if ({bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din} !== {1'b0, 1'b0, 4'd3, 8'h5A}) begin
            n_fail++;
            $display("FAIL wr_hold: wr/rd/addr/din=%b/%b/%h/%h required 0/0/3/5a",
                     bus.mem_wr, bus.mem_rd, bus.mem_addr, bus.mem_din);
        end
        tick();
        n_cmp++;
        if ({bus.ack_a, bus.ack_b} !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_ack: ack_a/ack_b=%b required 10", {bus.ack_a, bus.ack_b});
        end
        bus.req_a = 0;
        tick();
        n_cmp++;
        if ({bus.ack_a, bus.busy, 32'(wr_pulses - wr0)} !== {2'b00, 32'd1}) begin
            n_fail++;
            $display("FAIL wr_done: ack_a=%b busy=%b wr_pulses=%0d required 0 0 1",
                     bus.ack_a, bus.busy, wr_pulses - wr0);
        end
        refmem[3] = 8'h5A;
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'd3;
        lat = 0;
        while (!bus.ack_a && lat < 10) begin tick(); lat++; end
        n_cmp++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL rd_latency: edges=%0d required 3", lat);
        end
        n_cmp++;
        if (bus.rdata_a !== 8'h5A) begin
            n_fail++;
            $display("FAIL rd_data: rdata_a=%h required 5a", bus.rdata_a);
        end
        exp_rd_a = 8'h5A;
        bus.req_a = 0;
        tick();
        wait_idle();
    endtask

    task automatic test_simultaneous();
        int cyc, t_a, t_b;
        pulse_reset();
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4'd1; bus.wdata_a = 8'h11;
        bus.req_b = 1; bus.we_b = 1; bus.addr_b = 4'd2; bus.wdata_b = 8'h22;
        cyc = 0; t_a = -1; t_b = -1;
        while ((bus.req_a || bus.req_b) && cyc < 30) begin
            tick(); cyc++;
            if (bus.req_a && bus.ack_a) begin t_a = cyc; bus.req_a = 0; end
            if (bus.req_b && bus.ack_b) begin t_b = cyc; bus.req_b = 0; end
        end
        n_cmp++;
        if (t_a != 3 || t_b != 7) begin
            n_fail++;
            $display("FAIL tie_grant: ack_a at %0d ack_b at %0d required 3 and 7", t_a, t_b);
        end
        wait_idle();
        refmem[1] = 8'h11; refmem[2] = 8'h22;
        n_cmp++;
        if ({mem[1], mem[2]} !== 16'h1122) begin
            n_fail++;
            $display("FAIL tie_mem: mem[1]/mem[2]=%h required 1122", {mem[1], mem[2]});
        end
        bus.req_a = 1; bus.we_a = 0; bus.addr_a = 4'd2;
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'd1;
        cyc = 0; t_a = -1; t_b = -1;
        while ((bus.req_a || bus.req_b) && cyc < 30) begin
            tick(); cyc++;
            if (bus.req_a && bus.ack_a) begin t_a = cyc; bus.req_a = 0; end
            if (bus.req_b && bus.ack_b) begin t_b = cyc; bus.req_b = 0; end
        end
        n_cmp++;
        if (t_a != 3 || t_b != 7 || bus.rdata_a !== 8'h22 || bus.rdata_b !== 8'h11) begin
            n_fail++;
            $display("FAIL tie_ptr_back_to_a: ack_a@%0d ack_b@%0d rdata=%h required 3 7 2211",
                     t_a, t_b, {bus.rdata_a, bus.rdata_b});
        end
        exp_rd_a = 8'h22; exp_rd_b = 8'h11;
        wait_idle();
    endtask

    // Both requesters issue random transactions back to back; every completion is scored.
    task automatic run_traffic(input int na, input int nb);
        int         left[2];
        bit         wr[2];
        logic [3:0] ad[2];
        logic [7:0] wd[2];
        int         cyc, budget;
        logic       rq, ak;
        left = '{na, nb};
        order.delete();
        cyc = 0;
        budget = 20 * (na + nb) + 20;
        while ((left[0] > 0 || left[1] > 0) && cyc < budget) begin
            for (int p = 0; p < 2; p++) begin
                rq = (p == 0) ? bus.req_a : bus.req_b;
                ak = (p == 0) ? bus.ack_a : bus.ack_b;
                if (rq && ak) begin
                    order.push_back(p);
                    if (wr[p]) refmem[ad[p]] = wd[p];
                    else if (p == 0) exp_rd_a = refmem[ad[p]];
                    else exp_rd_b = refmem[ad[p]];
                    n_cmp++;
                    if ({bus.rdata_a, bus.rdata_b} !== {exp_rd_a, exp_rd_b}) begin
                        n_fail++;
                        $display("FAIL traffic_rdata: port %0d rdata_a/b=%h required %h",
                                 p, {bus.rdata_a, bus.rdata_b}, {exp_rd_a, exp_rd_b});
                    end
                    if (p == 0) bus.req_a = 0; else bus.req_b = 0;
                    left[p]--;
                end else if (!rq && !ak && left[p] > 0) begin
                    wr[p] = 1'($urandom_range(0, 1));
                    ad[p] = 4'($urandom_range(0, 15));
                    wd[p] = 8'($urandom);
                    if (p == 0) begin
                        bus.we_a = wr[p]; bus.addr_a = ad[p]; bus.wdata_a = wd[p]; bus.req_a = 1;
                    end else begin
                        bus.we_b = wr[p]; bus.addr_b = ad[p]; bus.wdata_b = wd[p]; bus.req_b = 1;
                    end
                end
            end
            tick(); cyc++;
        end
        n_cmp++;
        if (cyc >= budget) begin
            n_fail++;
            $display("FAIL traffic_timeout: %0d/%0d left after %0d cycles required 0/0",
                     left[0], left[1], cyc);
        end
        wait_idle();
    endtask

    task automatic test_round_robin();
        int ov0, bad;
        pulse_reset();
        ov0 = overlap;
        run_traffic(2, 2);
        bad = (order.size() != 4) ? 1 : 0;
        for (int k = 0; k < order.size() && k < 4; k++) if (order[k] != (k % 2)) bad = 1;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rr_order: grants=%p required '{0,1,0,1} (0=A 1=B)", order);
        end
        n_cmp++;
        if (overlap != ov0) begin
            n_fail++;
            $display("FAIL rr_overlap: wr&rd cycles=%0d required 0", overlap - ov0);
        end
    endtask

    task automatic test_drop_early();
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'd15;
        tick();
        n_cmp++;
        if ({bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.busy} !== {1'b1, 1'b0, 4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL drop_access: rd/wr/addr/busy=%b/%b/%h/%b required 1/0/f/1",
                     bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.busy);
        end
        bus.req_b = 0; bus.addr_b = 4'd0;
        tick();
        tick();
        exp_rd_b = refmem[15];
        n_cmp++;
        if ({bus.ack_a, bus.ack_b, bus.rdata_a, bus.rdata_b} !== {2'b01, exp_rd_a, exp_rd_b}) begin
            n_fail++;
            $display("FAIL drop_ack: ack=%b rdata=%h required 01 %h", {bus.ack_a, bus.ack_b},
                     {bus.rdata_a, bus.rdata_b}, {exp_rd_a, exp_rd_b});
        end
        tick();
        n_cmp++;
        if ({bus.ack_b, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_return: ack_b/busy=%b required 00", {bus.ack_b, bus.busy});
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4'd7; bus.wdata_a = 8'h77;
        tick();
        n_cmp++;
        if (bus.mem_wr !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: mem_wr=%b required 1", bus.mem_wr);
        end
        reset = 1;
        #1;
        n_cmp++;
        if ({bus.mem_wr, bus.mem_rd, bus.ack_a, bus.ack_b, bus.busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_ctrl: wr/rd/ack_a/ack_b/busy=%b required 00000",
                     {bus.mem_wr, bus.mem_rd, bus.ack_a, bus.ack_b, bus.busy});
        end
        n_cmp++;
        if ({bus.rdata_a, bus.rdata_b, bus.mem_addr, bus.mem_din} !== 28'h0) begin
            n_fail++;
            $display("FAIL rst_mid_data: rdata/addr/din=%h required 0",
                     {bus.rdata_a, bus.rdata_b, bus.mem_addr, bus.mem_din});
        end
        bus.req_a = 0;
        tick(); tick();
        reset = 0;
        exp_rd_a = 8'h00; exp_rd_b = 8'h00;
        n_cmp++;
        if (mem[7] !== refmem[7]) begin
            n_fail++;
            $display("FAIL rst_mem: mem[7]=%h required %h", mem[7], refmem[7]);
        end
        bus.req_b = 1; bus.we_b = 0; bus.addr_b = 4'd7;
        lat = 0;
        while (!bus.ack_b && lat < 10) begin tick(); lat++; end
        exp_rd_b = refmem[7];
        n_cmp++;
        if (lat != 3 || bus.rdata_b !== exp_rd_b || bus.rdata_a !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_after: edges=%0d rdata_b=%h rdata_a=%h required 3 %h 00",
                     lat, bus.rdata_b, bus.rdata_a, exp_rd_b);
        end
        bus.req_b = 0;
        tick();
        wait_idle();
    endtask

    task automatic test_random();
        int ov0, p0;
        ov0 = overlap;
        p0 = wr_pulses + rd_pulses;
        run_traffic(15, 15);
        n_cmp++;
        if (overlap != ov0 || (wr_pulses + rd_pulses - p0) != 30) begin
            n_fail++;
            $display("FAIL rand_strobes: overlap=%0d strobes=%0d required 0 30",
                     overlap - ov0, wr_pulses + rd_pulses - p0);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_simultaneous();
        test_round_robin();
        test_drop_early();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 4, memory address width (16 words).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_a, req_b  input  1 each  requester access request, level, held until ack.
REQ-006 we_a, we_b  input  1 each  1 = write, 0 = read; sampled with req.
REQ-007 addr_a, addr_b  input  ADDR_W each  requester address.
REQ-008 wdata_a, wdata_b  input  DATA_W each  requester write data.
REQ-009 ack_a, ack_b  output  1 each  transaction complete, held until req drops.
REQ-010 rdata_a, rdata_b  output  DATA_W each  registered read data per requester.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 mem_addr  output  ADDR_W, mem_din  output  DATA_W  memory address/write data.
REQ-013 mem_wr, mem_rd  output  1 each  memory write/read strobes.
REQ-014 mem_dout  input  DATA_W  memory read data, registered inside memory on the strobe edge.

Function
REQ-015 FSM states IDLE, ACCESS, LATCH, DONE; one transaction in flight at a time.
REQ-016 IDLE: at an edge with req_a or req_b high, select winner, latch its we/addr/wdata into internal registers, go ACCESS; otherwise stay.
REQ-017 Arbitration round-robin: pointer selects preferred requester on simultaneous requests; single request always wins; pointer toggles to the non-winner at every grant.
REQ-018 ACCESS (exactly one cycle): mem_addr/mem_din from latched registers; mem_wr = latched we, mem_rd = not latched we; go LATCH.
REQ-019 mem_wr and mem_rd never high together; both low in all states except ACCESS.
REQ-020 mem_addr/mem_din hold latched values outside ACCESS; requester input changes after grant edge have no effect.
REQ-021 LATCH: on exit edge, for reads load winner's rdata with mem_dout; for writes rdata unchanged; go DONE.
REQ-022 DONE: winner's ack high; stay while winner's req high; at first edge with winner's req low go IDLE, ack low.
REQ-023 Latency: ack visible 3 edges after the grant edge (grant edge, ACCESS, LATCH); next grant no earlier than edge after req drop.
REQ-024 Requester dropping req before ack: transaction still completes; ack high for exactly one cycle in DONE.
REQ-025 Non-winner request remains pending and is granted at the first IDLE edge; no request starved beyond one transaction.
REQ-026 Only the winner's ack/rdata change; loser outputs hold.

Reset
REQ-027 reset high forces immediately: state IDLE, ack_a/ack_b 0, rdata_a/rdata_b 0, busy 0, mem_wr/mem_rd 0, mem_addr/mem_din 0, pointer preferring A.
REQ-028 Reset mid-transaction abandons it; no strobe after reset; memory content written before reset untouched by this block.

Verification
REQ-029 A writes 0x5A to addr 3, then reads addr 3 -> mem_wr one cycle with mem_addr=3, mem_din=0x5A; read ack with rdata_a=0x5A, 3 edges after grant.
REQ-030 req_a and req_b high on same edge after reset (A write 0x11 @1, B write 0x22 @2) -> A granted first, B granted next IDLE edge; pointer then prefers A.
REQ-031 Both requesters held continuously, 4 transactions -> grants A,B,A,B; mem_wr and mem_rd never simultaneously high.
REQ-032 B read addr 15 with req dropped during ACCESS -> ack_b one cycle, rdata_b = mem_dout, return IDLE.
REQ-033 reset asserted during ACCESS of A write -> strobes low immediately, acks 0, rdata 0, busy 0; after release, new B request granted normally.
